mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_if.sv | 10 +
 rtl/mem_loader.sv | 113 +++++++++++
 tb/tb_mem_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_if.sv
// Byte-stream handshake into the memory loader: the source drives valid/data
// and the loader answers with ready.
interface mem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mem_loader.sv
// Boot loader: streams a length-prefixed, checksummed image into a 256-byte
// memory, then releases the processor and hands it the memory bus.
module mem_loader (
  input  logic        clk,
  input  logic        reset,
  mem_loader_if.slave stream,
  input  logic        reload,
  input  logic        cpu_memwrite,
  input  logic [7:0]  cpu_adr,
  input  logic [7:0]  cpu_writedata,
  output logic        mem_memwrite,
  output logic [7:0]  mem_adr,
  output logic [7:0]  mem_writedata,
  output logic        cpu_run,
  output logic        load_error
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_t;

  state_t     state, state_nxt;
  logic [7:0] len, len_nxt;
  logic [7:0] count, count_nxt;
  logic [7:0] sum, sum_nxt;
  logic       err_nxt;
  logic       ready;
  logic       xfer;

  assign stream.in_ready = ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len        <= 8'd0;
      count      <= 8'd0;
      sum        <= 8'd0;
      cpu_run    <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      len        <= len_nxt;
      count      <= count_nxt;
      sum        <= sum_nxt;
      cpu_run    <= (state_nxt == RUN);
      load_error <= err_nxt;
    end
  end

  // Ready is gated by reset so a byte presented during reset is never taken.
  always_comb begin
    state_nxt     = state;
    len_nxt       = len;
    count_nxt     = count;
    sum_nxt       = sum;
    err_nxt       = load_error;
    ready         = reset && (state == IDLE || state == LOAD || state == CHECK);
    xfer          = stream.in_valid && ready;
    mem_memwrite  = 1'b0;
    mem_adr       = count;
    mem_writedata = stream.in_data;

    case (state)
      IDLE: begin
        if (xfer) begin
          len_nxt   = stream.in_data;
          count_nxt = 8'd0;
          sum_nxt   = 8'd0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        mem_memwrite = xfer;
        if (xfer) begin
          count_nxt = count + 8'd1;
          sum_nxt   = sum + stream.in_data;
          // A length byte of zero wraps len-1 to 255, giving a full 256-byte image.
          if (count == len - 8'd1)
            state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (xfer) begin
          if (stream.in_data == sum) begin
            state_nxt = RUN;
          end else begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end
        end
      end
      RUN: begin
        mem_memwrite  = cpu_memwrite;
        mem_adr       = cpu_adr;
        mem_writedata = cpu_writedata;
        if (reload) begin
          state_nxt = IDLE;
          count_nxt = 8'd0;
          sum_nxt   = 8'd0;
          err_nxt   = 1'b0;
        end
      end
      ERROR: begin
        if (reload) begin
          state_nxt = IDLE;
          count_nxt = 8'd0;
          sum_nxt   = 8'd0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: directed image loads plus randomized
// loads, compared against a byte-level model of the external memory.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       reload;
  logic       cpu_memwrite;
  logic [7:0] cpu_adr;
  logic [7:0] cpu_writedata;
  logic       mem_memwrite;
  logic [7:0] mem_adr;
  logic [7:0] mem_writedata;
  logic       cpu_run;
  logic       load_error;
  logic       seedNow;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] extMem [256];
  logic [7:0] refMem [256];
  logic [7:0] payload [$];

  mem_loader_if stream();

  mem_loader dut (
    .clk           (clk),
    .reset         (reset),
    .stream        (stream),
    .reload        (reload),
    .cpu_memwrite  (cpu_memwrite),
    .cpu_adr       (cpu_adr),
    .cpu_writedata (cpu_writedata),
    .mem_memwrite  (mem_memwrite),
    .mem_adr       (mem_adr),
    .mem_writedata (mem_writedata),
    .cpu_run       (cpu_run),
    .load_error    (load_error)
  );

  always #5 clk = ~clk;

  // External 256-byte memory, preloaded with the same random image as the model.
  always @(posedge clk) begin
    if (seedNow) begin
      for (int i = 0; i < 256; i++) extMem[i] <= refMem[i];
    end else if (mem_memwrite) begin
      extMem[mem_adr] <= mem_writedata;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic randomCpu();
    cpu_memwrite  = 1'($urandom_range(0, 1));
    cpu_adr       = 8'($urandom);
    cpu_writedata = 8'($urandom);
  endtask

  function automatic logic [7:0] payloadSum();
    logic [7:0] s = 8'd0;
    foreach (payload[i]) s = s + payload[i];
    return s;
  endfunction

  // role: 0 = length byte, 1 = data byte at address idx, 2 = checksum byte.
  // gapMode: 0 = back-to-back, 1 = random idle cycles, 2 = one idle cycle each.
  task automatic applyStimulus(input logic [7:0] b, input int role, input int idx, input int gapMode);
    int gaps;
    gaps = (gapMode == 0) ? 0 : (gapMode == 2) ? 1 : int'($urandom_range(0, 2));
    for (int g = 0; g < gaps; g++) begin
      stream.in_valid = 1'b0;
      stream.in_data  = 8'($urandom);
      randomCpu();
      reload = 1'($urandom_range(0, 1));
      #1;
      checkOutput("idleNoWrite", 16'(mem_memwrite), 16'd0);
      checkOutput("idleReady", 16'(stream.in_ready), 16'd1);
      @(negedge clk);
    end
    stream.in_valid = 1'b1;
    stream.in_data  = b;
    randomCpu();
    reload = 1'($urandom_range(0, 1));
    #1;
    checkOutput("inReady", 16'(stream.in_ready), 16'd1);
    if (role == 1) begin
      checkOutput("loadWrite", 16'(mem_memwrite), 16'd1);
      checkOutput("loadAdr", 16'(mem_adr), 16'(idx));
      checkOutput("loadData", 16'(mem_writedata), 16'(b));
    end else begin
      checkOutput("noWrite", 16'(mem_memwrite), 16'd0);
    end
    @(negedge clk);
    stream.in_valid = 1'b0;
    reload          = 1'b0;
    cpu_memwrite    = 1'b0;
  endtask

  task automatic doLoad(input logic [7:0] chk, input int gapMode);
    int         n;
    logic [7:0] lenByte;
    logic [7:0] s;
    bit         ok;
    n       = payload.size();
    lenByte = n[7:0];
    s       = payloadSum();
    ok      = (chk == s);
    applyStimulus(lenByte, 0, 0, gapMode);
    for (int i = 0; i < n; i++) begin
      applyStimulus(payload[i], 1, i, gapMode);
      refMem[i] = payload[i];
    end
    applyStimulus(chk, 2, 0, gapMode);
    checkOutput("cpuRun", 16'(cpu_run), 16'(ok));
    checkOutput("loadError", 16'(load_error), 16'(!ok));
    checkOutput("readyAfter", 16'(stream.in_ready), 16'd0);
    if (!ok) begin
      cpu_memwrite  = 1'b1;
      cpu_adr       = 8'($urandom);
      cpu_writedata = 8'($urandom);
      #1;
      checkOutput("errNoWrite", 16'(mem_memwrite), 16'd0);
      @(negedge clk);
      cpu_memwrite = 1'b0;
      checkOutput("errHold", 16'(load_error), 16'd1);
      checkOutput("errCpuRun", 16'(cpu_run), 16'd0);
    end
  endtask

  task automatic cpuWrite(input logic [7:0] adr, input logic [7:0] data);
    cpu_memwrite  = 1'b1;
    cpu_adr       = adr;
    cpu_writedata = data;
    #1;
    checkOutput("cpuFwdWe", 16'(mem_memwrite), 16'd1);
    checkOutput("cpuFwdAdr", 16'(mem_adr), 16'(adr));
    checkOutput("cpuFwdData", 16'(mem_writedata), 16'(data));
    @(negedge clk);
    refMem[adr]  = data;
    cpu_memwrite = 1'b0;
    cpu_adr      = 8'($urandom);
    #1;
    checkOutput("cpuReadAdr", 16'(mem_adr), 16'(cpu_adr));
    checkOutput("runHold", 16'(cpu_run), 16'd1);
    @(negedge clk);
  endtask

  task automatic doReload();
    reload       = 1'b1;
    cpu_memwrite = 1'b0;
    @(negedge clk);
    reload        = 1'b0;
    cpu_memwrite  = 1'b1;
    cpu_adr       = 8'($urandom);
    cpu_writedata = 8'($urandom);
    #1;
    checkOutput("reloadNoFwd", 16'(mem_memwrite), 16'd0);
    checkOutput("reloadCpuRun", 16'(cpu_run), 16'd0);
    checkOutput("reloadErr", 16'(load_error), 16'd0);
    checkOutput("reloadReady", 16'(stream.in_ready), 16'd1);
    @(negedge clk);
    cpu_memwrite = 1'b0;
  endtask

  task automatic checkMemory();
    for (int i = 0; i < 256; i++)
      checkOutput($sformatf("mem[%02h]", i), 16'(extMem[i]), 16'(refMem[i]));
  endtask

  initial begin
    logic [7:0] s;
    int         n;
    for (int i = 0; i < 256; i++) refMem[i] = 8'($urandom);
    seedNow         = 1'b1;
    reset           = 1'b1;
    reload          = 1'b0;
    cpu_memwrite    = 1'b0;
    cpu_adr         = 8'd0;
    cpu_writedata   = 8'd0;
    stream.in_valid = 1'b0;
    stream.in_data  = 8'd0;

    #2 reset = 1'b0;
    #1;
    checkOutput("rstReady", 16'(stream.in_ready), 16'd0);
    checkOutput("rstCpuRun", 16'(cpu_run), 16'd0);
    checkOutput("rstErr", 16'(load_error), 16'd0);
    checkOutput("rstWrite", 16'(mem_memwrite), 16'd0);
    checkOutput("rstAdr", 16'(mem_adr), 16'd0);
    @(negedge clk);
    seedNow = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("postRstReady", 16'(stream.in_ready), 16'd1);
    @(negedge clk);

    $display("[TB] three-byte load with good checksum");
    payload = '{8'h10, 8'h20, 8'h30};
    doLoad(8'h60, 0);
    checkMemory();

    $display("[TB] processor write in RUN, then reload");
    cpuWrite(8'h40, 8'h5A);
    doReload();
    checkMemory();

    $display("[TB] two-byte load with bad checksum");
    payload = '{8'hAA, 8'hBB};
    doLoad(8'h00, 0);
    checkMemory();
    doReload();

    $display("[TB] full 256-byte load");
    payload.delete();
    for (int i = 0; i < 256; i++) payload.push_back(8'(i));
    doLoad(8'h80, 0);
    checkMemory();
    doReload();

    $display("[TB] load with valid toggling every cycle");
    payload = '{8'h10, 8'h20, 8'h30};
    doLoad(8'h60, 2);
    checkMemory();
    doReload();

    $display("[TB] reset in the middle of a load");
    payload = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    applyStimulus(8'h04, 0, 0, 0);
    applyStimulus(payload[0], 1, 0, 0);
    refMem[0] = payload[0];
    applyStimulus(payload[1], 1, 1, 0);
    refMem[1] = payload[1];
    stream.in_valid = 1'b1;
    stream.in_data  = payload[2];
    #2 reset = 1'b0;
    #1;
    checkOutput("midRstReady", 16'(stream.in_ready), 16'd0);
    checkOutput("midRstWrite", 16'(mem_memwrite), 16'd0);
    checkOutput("midRstCpuRun", 16'(cpu_run), 16'd0);
    @(negedge clk);
    stream.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midRstIdle", 16'(stream.in_ready), 16'd1);
    checkOutput("midRstAdr", 16'(mem_adr), 16'd0);
    @(negedge clk);
    payload = '{8'h77};
    doLoad(8'h77, 0);
    checkMemory();
    doReload();

    $display("[TB] randomized loads");
    for (int t = 0; t < 8; t++) begin
      n = int'($urandom_range(1, 24));
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
      s = payloadSum();
      if ($urandom_range(0, 2) != 0) begin
        doLoad(s, 1);
        for (int k = 0; k < 3; k++) cpuWrite(8'($urandom), 8'($urandom));
      end else begin
        doLoad(s ^ 8'($urandom_range(1, 255)), 1);
      end
      checkMemory();
      doReload();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
